// File: rtl/mire_wshb.sv
// Wishbone master that paints a grid + per-frame colour test pattern into the frame buffer,
// one word per pixel in raster order, releasing cyc every BURST words to share the slave.
module mire_wshb #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GRID  = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  input  logic        err,
  input  logic        rty,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [XW-1:0] X_LAST     = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(VDISP - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

  state_t        state;
  logic [XW-1:0] x, nx, px;
  logic [YW-1:0] y, ny, py;
  logic [BW-1:0] burst_cnt;
  logic          last_pixel;
  logic [31:0]   word_adr, word_dat;

  // err/rty without ack leave the current word pending, so it is simply presented again.
  logic unused_resp;
  assign unused_resp = err | rty;

  assign cti = 3'b000;
  assign bte = 2'b00;

  function automatic logic [31:0] pix_adr(input logic [XW-1:0] fx, input logic [YW-1:0] fy);
    return (32'(fy) * 32'(HDISP) + 32'(fx)) << 2;
  endfunction

  function automatic logic [31:0] pix_dat(input logic [XW-1:0] fx, input logic [YW-1:0] fy,
                                          input logic [7:0] f);
    if (((32'(fx) & 32'(GRID - 1)) == 32'd0) || ((32'(fy) & 32'(GRID - 1)) == 32'd0))
      return 32'h00FF_FFFF;
    return {8'h00, f, 8'(fx), 8'(fy)};
  endfunction

  // While writing, the word to load next is the one after the pixel being acked;
  // when (re)starting a burst it is the pixel the counters already point at.
  always_comb begin
    last_pixel = (x == X_LAST) && (y == Y_LAST);
    nx = x;
    ny = y;
    if (x == X_LAST) begin
      nx = '0;
      ny = (y == Y_LAST) ? '0 : y + 1'b1;
    end else begin
      nx = x + 1'b1;
    end
    px = (state == WRITE) ? nx : x;
    py = (state == WRITE) ? ny : y;
    word_adr = pix_adr(px, py);
    word_dat = pix_dat(px, py, frame_cnt);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      burst_cnt  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      we         <= 1'b0;
      sel        <= 4'h0;
      adr        <= '0;
      dat_ms     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= WRITE;
            cyc    <= 1'b1;
            stb    <= 1'b1;
            we     <= 1'b1;
            sel    <= 4'hF;
            adr    <= word_adr;
            dat_ms <= word_dat;
          end
        end
        WRITE: begin
          if (ack) begin
            if (last_pixel || burst_cnt == BURST_LAST) begin
              state     <= PAUSE;
              burst_cnt <= '0;
              cyc       <= 1'b0;
              stb       <= 1'b0;
              we        <= 1'b0;
              sel       <= 4'h0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
              adr       <= word_adr;
              dat_ms    <= word_dat;
            end
            x <= nx;
            y <= ny;
            if (last_pixel) begin
              frame_cnt  <= frame_cnt + 8'd1;
              frame_done <= 1'b1;
            end
          end
        end
        PAUSE: begin
          // A frame in progress is always finished, whatever enable says.
          if (enable || x != '0 || y != '0) begin
            state  <= WRITE;
            cyc    <= 1'b1;
            stb    <= 1'b1;
            we     <= 1'b1;
            sel    <= 4'hF;
            adr    <= word_adr;
            dat_ms <= word_dat;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mire_wshb.sv
// Scoreboard bench for mire_wshb: a frame-level model queues expected words,
// a monitor pops them on every acked write and checks bus timing.
module tb_mire_wshb;

  localparam int H = 32;
  localparam int V = 4;
  localparam int B = 12;
  localparam int G = 16;
  localparam int NPIX = H * V;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        enable;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    bit          last;
  } word_t;

  word_t exp_q[$];

  mire_wshb #(.HDISP(H), .VDISP(V), .BURST(B), .GRID(G)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms), .sel(sel),
    .cti(cti), .bte(bte), .ack(ack), .err(err), .rty(rty),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input int m);
    @(negedge sys_clk);
    #2;
    enable = en;
    mode   = m;
  endtask

  task automatic pushFrame(input int f);
    word_t w;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        w.adr  = 32'(4 * (yy * H + xx));
        w.dat  = ((xx % G == 0) || (yy % G == 0)) ? 32'h00FF_FFFF
                 : 32'(((f % 256) << 16) | ((xx % 256) << 8) | (yy % 256));
        w.last = (xx == H - 1) && (yy == V - 1);
        exp_q.push_back(w);
      end
  endtask

  task automatic waitWord(input string name, input logic [31:0] a, input int fc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (stb && adr == a && (fc < 0 || int'(frame_cnt) == fc)) found = 1'b1;
    end
    checkOutput(name, 128'(found), 128'd1);
  endtask

  task automatic waitFrameDone(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (frame_done) found = 1'b1;
    end
    checkOutput("frame_done_seen", 128'(found), 128'd1);
  endtask

  // Reference model: whole frames of expected words, restarted at frame 0 by reset.
  int gen_f = 0;
  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    if (sys_rst) begin
      exp_q.delete();
      gen_f = 0;
    end else if (exp_q.size() < NPIX) begin
      pushFrame(gen_f);
      gen_f++;
    end
  end

  // Slave responder: ack/err/rty decided half a cycle before the edge that samples them.
  initial begin
    int r;
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    forever begin
      @(negedge sys_clk);
      #2;
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (!sys_rst && stb) begin
        if (mode == 0) ack = 1'b1;
        else if (mode == 1) begin
          r = $urandom_range(0, 7);
          ack = (r <= 2);
          err = (r == 0) || (r == 3);
          rty = (r == 1) || (r == 4);
        end
      end
    end
  end

  typedef enum {M_IDLE, M_BUSY, M_PAUSE} mphase_t;
  mphase_t    phase = M_IDLE;
  int         pix_idx = 0;
  int         burst_n = 0;
  logic [7:0] exp_fc = 8'd0;
  bit         prev_stb = 1'b0;
  bit         acc, last, exp_cyc;
  word_t      mon_e;

  // Monitor: pops on each acked word and derives the expected bus phase from burst/frame rules.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      checkOutput("reset_outputs",
                  128'({cyc, stb, we, adr, dat_ms, sel, cti, bte, frame_done, frame_cnt}), 128'd0);
      phase = M_IDLE; pix_idx = 0; burst_n = 0; exp_fc = 8'd0; prev_stb = 1'b0;
    end else begin
      acc  = prev_stb && ack;
      last = 1'b0;
      if (acc) begin
        checkOutput("queue_nonempty_on_ack", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          last  = mon_e.last;
        end
        pix_idx = (pix_idx + 1) % NPIX;
        burst_n++;
        if (last) exp_fc = exp_fc + 8'd1;
      end
      checkOutput("frame_done", 128'(frame_done), 128'(last));
      checkOutput("frame_cnt", 128'(frame_cnt), 128'(exp_fc));
      case (phase)
        M_IDLE:  exp_cyc = enable;
        M_BUSY:  exp_cyc = !(acc && (last || burst_n == B));
        default: exp_cyc = enable || (pix_idx != 0);
      endcase
      if (phase == M_BUSY && !exp_cyc) burst_n = 0;
      phase = exp_cyc ? M_BUSY : ((phase == M_BUSY) ? M_PAUSE : M_IDLE);
      checkOutput("cyc_stb", 128'({cyc, stb}), 128'({exp_cyc, exp_cyc}));
      checkOutput("cti_bte", 128'({cti, bte}), 128'd0);
      if (stb) begin
        checkOutput("we_sel", 128'({we, sel}), 128'({1'b1, 4'hF}));
        checkOutput("queue_nonempty_on_stb", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0)
          checkOutput("adr_dat", 128'({adr, dat_ms}), 128'({exp_q[0].adr, exp_q[0].dat}));
      end
      prev_stb = stb;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enable = 1'b1;
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("first_word", 128'({stb, adr, dat_ms}), 128'({1'b1, 32'h0, 32'h00FF_FFFF}));

    waitWord("reach_word17", 32'h44, 0, 100);
    checkOutput("word17_dat", 128'(dat_ms), 128'h00FF_FFFF);
    waitFrameDone(1000);
    checkOutput("frame_cnt_after_frame0", 128'(frame_cnt), 128'd1);
    waitWord("reach_pixel_1_1_frame1", 32'h84, 1, 200);
    checkOutput("pixel_1_1_frame1_dat", 128'(dat_ms), 128'h0001_0101);
    waitFrameDone(1000);

    $display("[TB] random wait states with err/rty");
    applyStimulus(1'b1, 1);
    waitFrameDone(3000);
    waitFrameDone(3000);

    $display("[TB] enable dropped mid-frame");
    waitWord("reach_mid_frame", 32'h100, -1, 3000);
    applyStimulus(1'b0, 1);
    waitFrameDone(3000);
    repeat (6) @(negedge sys_clk);
    checkOutput("idle_after_drop", 128'({cyc, stb}), 128'd0);
    applyStimulus(1'b1, 0);
    @(negedge sys_clk);
    checkOutput("restart_adr", 128'({stb, adr}), 128'({1'b1, 32'h0}));

    $display("[TB] async reset during pending write");
    applyStimulus(1'b1, 2);
    repeat (4) @(negedge sys_clk);
    checkOutput("pre_rst_stb", 128'(stb), 128'd1);
    #3 sys_rst = 1'b1;
    #1 checkOutput("rst_drops_bus", 128'({cyc, stb}), 128'd0);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    mode = 0;
    @(negedge sys_clk);
    checkOutput("post_rst_restart", 128'({stb, adr, frame_cnt}), 128'({1'b1, 32'h0, 8'h0}));

    $display("[TB] random enable toggling");
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)));
      repeat ($urandom_range(5, 40)) @(negedge sys_clk);
    end
    applyStimulus(1'b1, 0);
    repeat (20) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
